// File: rtl/lj16_pkg.sv
// Shared widths, the stereo sample-pair type and lrck polarity for the LJ16 serializer.
package lj16_pkg;

  localparam int WORD_BITS       = 16;
  localparam int FRAME_BITS      = 32;
  localparam int HALF_FRAME_BITS = 16;
  localparam logic LRCK_LEFT     = 1'b0;

  typedef struct packed {
    logic signed [WORD_BITS-1:0] l;
    logic signed [WORD_BITS-1:0] r;
  } pair_t;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Left channel occupies the upper half so it is shifted out first.
  function automatic frame_t pair_to_frame(input pair_t p);
    return {p.l, p.r};
  endfunction

endpackage

// File: rtl/lj16_pair_fifo.sv
// Synchronous FIFO of stereo sample pairs; show-ahead read, push ignored when full,
// pop ignored when empty.
module lj16_pair_fifo
  import lj16_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  pair_t wr_data,
  input  logic  pop,
  output pair_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  pair_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds data only; flushing is done by the pointer/count reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/lj16_serializer.sv
// Parallel stereo samples in, bck/lrck/left-justified 16-bit serial data out.
// Define LJ16_UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of silence.
module lj16_serializer
  import lj16_pkg::*;
#(
  parameter int BCK_DIV    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bck,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int DIV_W = $clog2(BCK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  frame_t           shift_q, shift_d;
  frame_t           frame_word, underrun_word;
  logic             div_last, bit_tick, load;
  pair_t            in_pair, fifo_rd;
  logic             fifo_full, fifo_empty, fifo_push;
`ifdef LJ16_UNDERRUN_HOLD_EN
  frame_t           hold_q, hold_d;
`endif

  assign in_ready    = !fifo_full;
  assign fifo_push   = in_valid && in_ready;
  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  always_comb begin
    in_pair.l = in_l;
    in_pair.r = in_r;
  end

  lj16_pair_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (mclk),
    .rst    (rst),
    .push   (fifo_push),
    .wr_data(in_pair),
    .pop    (load),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    div_last      = (div_cnt_q == DIV_W'(BCK_DIV - 1));
    bit_tick      = (div_cnt_q == '0);
    load          = bit_tick && (bit_cnt_q == '0);
    div_cnt_d     = div_last ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d     = div_last ? bit_cnt_q + 1'b1 : bit_cnt_q;
    // bck falls on the same mclk edge that updates lrck/sdata.
    bck_d         = (div_cnt_q >= DIV_W'(BCK_DIV / 2));
    frame_start_d = load;
    underrun_d    = (load && fifo_empty) || (underrun_q && !underrun_clr);
`ifdef LJ16_UNDERRUN_HOLD_EN
    underrun_word = hold_q;
    hold_d        = (load && !fifo_empty) ? pair_to_frame(fifo_rd) : hold_q;
`else
    underrun_word = '0;
`endif
    frame_word    = fifo_empty ? underrun_word : pair_to_frame(fifo_rd);
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    shift_d       = shift_q;
    if (bit_tick) begin
      lrck_d = (bit_cnt_q < BIT_W'(HALF_FRAME_BITS)) ? LRCK_LEFT : !LRCK_LEFT;
      // MSB goes straight to sdata so it lines up with the lrck edge.
      if (load) begin
        {sdata_d, shift_d} = {frame_word, 1'b0};
      end else begin
        {sdata_d, shift_d} = {shift_q, 1'b0};
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      bck_q         <= 1'b0;
      lrck_q        <= LRCK_LEFT;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bck_q         <= bck_d;
      lrck_q        <= lrck_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Always reloaded at the first frame after reset, so no reset is needed.
  always_ff @(posedge mclk) begin
    shift_q <= shift_d;
  end

`ifdef LJ16_UNDERRUN_HOLD_EN
  always_ff @(posedge mclk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

endmodule
